seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Multi-cycle restoring divider for the MIPS DIV/DIVU instructions. It is the inverse
//  companion of the Booth multiplier and sits beside it in the HI/LO unit.
//  Produces a quotient (to LO) and a remainder (to HI), one quotient bit per cycle.
//  Uses the same START/busy/ready handshake as the multiplier, so the control FSM
//  drives both units identically.
// PARAMETERS
//  N  32  operand width (bits)
//  S  5   iteration-counter width; counter is S+1 bits (holds 0..N)
// PORTS
//  CLK           in   1  clock, rising edge
//  RST           in   1  reset, asynchronous, active-low
//  START         in   1  1-cycle pulse; operands are sampled on this edge
//  SIGNED        in   1  1 = DIV (two's complement), 0 = DIVU; sampled with START
//  dividend      in   N  numerator
//  divisor       in   N  denominator
//  quotient      out  N  registered result (to LO)
//  remainder     out  N  registered result (to HI)
//  ready         out  1  high while quotient/remainder hold a completed result
//  busy          out  1  high while an operation is in progress
//  div_by_zero   out  1  high with ready when the sampled divisor was 0
// BEHAVIOUR
//  Reset (RST=0): state=IDLE; quotient, remainder, ready, busy, div_by_zero all 0.
//    All internal registers are cleared. Reset aborts any operation in flight.
//  States:
//    IDLE -START-> RUN (or FIX when divisor==0)
//    RUN  -(count==0 after step)-> FIX
//    FIX  -> DONE
//    DONE -START-> RUN/FIX
//  START edge, any state:
//    - latch sign_q = SIGNED & (dividend[N-1]^divisor[N-1]);
//      latch sign_r = SIGNED & dividend[N-1]
//    - latch operand magnitudes: negate an operand only if SIGNED and its MSB=1
//    - clear the N+1-bit partial remainder; count=N
//    - ready=0, div_by_zero=0, busy=1
//    - START during RUN/FIX restarts: the old operation is discarded and never reported.
//  RUN, each edge (one restoring step):
//    - R' = {R[N-1:0], Qreg[N-1]}; T = R' - {1'b0,|divisor|}
//    - if T >= 0: R=T, shift quotient bit 1 into Qreg; else R=R', shift in 0
//    - count--
//  FIX edge:
//    - quotient  = sign_q ? -Qreg : Qreg
//    - remainder = sign_r ? -R[N-1:0] : R[N-1:0]
//    - busy=0, ready=1
//    - results truncate toward zero; remainder takes the sign of the dividend
//  Latency: ready rises N+1 edges after the START edge (33 for N=32). Throughput is one op per N+2 cycles.
//  Divide by zero: START goes straight to FIX.
//    quotient = {N{1'b1}}, remainder = dividend (raw), div_by_zero = 1.
//    ready rises 1 edge after START.
//  Overflow: signed 0x80000000 / -1 gives quotient 0x80000000, remainder 0 (wraps). No flag.
//  DONE holds outputs stable until the next START. Outputs change only in FIX or on reset.
//  busy and ready are never both 1.
// STRUCTURE
//  Shared package mips_muldiv_pkg holds:
//    - state encoding localparams (IDLE/RUN/FIX/DONE)
//    - DIV0_QUOTIENT constant
//    - N default shared with the multiplier
//  Sub-module div_step (combinational): inputs R, next dividend bit, |divisor|;
//    outputs next R and the quotient bit. The top level holds the FSM, counter, and sign/negate logic.
// TESTING (N=32)
//  1. DIVU 100/7 -> q=14, r=2, div_by_zero=0. ready rises exactly 33 cycles after START; busy high for cycles 1..32.
//  2. DIV -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF. DIV 7/-2 -> q=0xFFFFFFFD, r=1. DIV -7/-2 -> q=3, r=0xFFFFFFFF.
//  3. DIVU 0x12345678/0 -> q=0xFFFFFFFF, r=0x12345678, div_by_zero=1, ready 1 cycle after START.
//     The next START must clear div_by_zero.
//  4. DIV 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0. DIVU of the same operands -> q=0, r=0x80000000.
//  5. Restart and reset:
//     - START 1000/3, then START 50/5 at cycle 10 -> only q=10, r=0 is reported, 33 cycles after the second START.
//     - RST low mid-RUN -> all outputs 0 and state IDLE.
//  6. 10k random operand pairs in both modes, including 0, 1, -1, and min/max values.
//     Compare against a behavioural / and % model; check that operand changes after START have no effect.

Source files
------------

// File: rtl/mips_muldiv_pkg.sv
// Definitions shared by the HI/LO unit's sequential multiplier and divider.
// Holds the default operand width, the FSM encoding and the divide-by-zero quotient.
package mips_muldiv_pkg;

   localparam int unsigned MulDivWidth    = 32;
   localparam int unsigned MulDivCntWidth = 5;

   localparam logic [1:0] StEncIdle = 2'd0;
   localparam logic [1:0] StEncRun  = 2'd1;
   localparam logic [1:0] StEncFix  = 2'd2;
   localparam logic [1:0] StEncDone = 2'd3;

   typedef enum logic [1:0] {
      StIdle = StEncIdle,
      StRun  = StEncRun,
      StFix  = StEncFix,
      StDone = StEncDone
   } div_state_e;

   localparam logic [MulDivWidth-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor magnitude when that does not go negative.
module div_step #(
   parameter int unsigned N = 32
) (
   input  logic [N:0]   rem_i,
   input  logic         bit_i,
   input  logic [N-1:0] dvs_i,
   output logic [N:0]   rem_o,
   output logic         q_o
);

   logic [N+1:0] r_shift;
   logic [N+1:0] dvs_ext;

   always_comb begin
      r_shift = {rem_i, bit_i};
      dvs_ext = {2'b00, dvs_i};
      q_o     = (r_shift >= dvs_ext);
      rem_o   = q_o ? (N+1)'(r_shift - dvs_ext) : (N+1)'(r_shift);
   end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU: quotient to LO, remainder to HI,
// one quotient bit per cycle, START/busy/ready handshake shared with the multiplier.
module seq_divider
   import mips_muldiv_pkg::*;
#(
   parameter int unsigned N = MulDivWidth,
   parameter int unsigned S = MulDivCntWidth
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         START,
   input  logic         SIGNED,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         ready,
   output logic         busy,
   output logic         div_by_zero
);

   div_state_e   state_q, state_d;
   logic [S:0]   cnt_q, cnt_d;
   logic [N:0]   rem_q, rem_d;
   logic [N-1:0] qreg_q, qreg_d;
   logic [N-1:0] dvs_q, dvs_d;
   logic         neg_quo_q, neg_quo_d;
   logic         neg_rem_q, neg_rem_d;
   logic         div0_q, div0_d;
   logic [N-1:0] quotient_q, quotient_d;
   logic [N-1:0] remainder_q, remainder_d;
   logic         ready_q, ready_d;
   logic         busy_q, busy_d;
   logic         dbz_q, dbz_d;

   logic [N:0]   step_rem;
   logic         step_bit;
   logic [N-1:0] dvd_mag, dvs_mag;
   logic [N-1:0] quo_fix, rem_fix;

   div_step #(
      .N(N)
   ) u_div_step (
      .rem_i (rem_q),
      .bit_i (qreg_q[N-1]),
      .dvs_i (dvs_q),
      .rem_o (step_rem),
      .q_o   (step_bit)
   );

   always_comb begin
      dvd_mag = (SIGNED && dividend[N-1]) ? -dividend : dividend;
      dvs_mag = (SIGNED && divisor[N-1])  ? -divisor  : divisor;

      // On divide-by-zero qreg still holds the dividend magnitude, so re-applying
      // the dividend sign recovers the raw dividend for HI.
      if (div0_q) begin
         quo_fix = {N{&DIV0_QUOTIENT}};
         rem_fix = neg_rem_q ? -qreg_q : qreg_q;
      end else begin
         quo_fix = neg_quo_q ? -qreg_q : qreg_q;
         rem_fix = neg_rem_q ? -rem_q[N-1:0] : rem_q[N-1:0];
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      qreg_d      = qreg_q;
      dvs_d       = dvs_q;
      neg_quo_d   = neg_quo_q;
      neg_rem_d   = neg_rem_q;
      div0_d      = div0_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      ready_d     = ready_q;
      busy_d      = busy_q;
      dbz_d       = dbz_q;

      unique case (state_q)
         StIdle, StDone: begin
         end
         StRun: begin
            rem_d  = step_rem;
            qreg_d = {qreg_q[N-2:0], step_bit};
            cnt_d  = cnt_q - (S+1)'(1);
            if (cnt_q == (S+1)'(1)) begin
               state_d = StFix;
            end
         end
         StFix: begin
            quotient_d  = quo_fix;
            remainder_d = rem_fix;
            dbz_d       = div0_q;
            busy_d      = 1'b0;
            ready_d     = 1'b1;
            state_d     = StDone;
         end
      endcase

      // START wins in every state; an operation in flight is silently discarded.
      if (START) begin
         neg_quo_d = SIGNED & (dividend[N-1] ^ divisor[N-1]);
         neg_rem_d = SIGNED & dividend[N-1];
         qreg_d    = dvd_mag;
         dvs_d     = dvs_mag;
         rem_d     = '0;
         cnt_d     = (S+1)'(N);
         div0_d    = (divisor == '0);
         ready_d   = 1'b0;
         dbz_d     = 1'b0;
         busy_d    = 1'b1;
         state_d   = (divisor == '0) ? StFix : StRun;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         rem_q       <= '0;
         qreg_q      <= '0;
         dvs_q       <= '0;
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         div0_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         qreg_q      <= qreg_d;
         dvs_q       <= dvs_d;
         neg_quo_q   <= neg_quo_d;
         neg_rem_q   <= neg_rem_d;
         div0_q      <= div0_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         dbz_q       <= dbz_d;
      end
   end

   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign ready       = ready_q;
   assign busy        = busy_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed DIV/DIVU vectors with hand-computed
// results, restart and reset-in-flight scenarios, latency and handshake checks.
module tb_seq_divider;

   logic        CLK;
   logic        RST;
   logic        START;
   logic        SIGNED;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        ready;
   logic        busy;
   logic        div_by_zero;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      int          start;
      int          lat;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   n_cmp  = 0;
   int   n_fail = 0;

   seq_divider #(
      .N(32),
      .S(5)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .START       (START),
      .SIGNED      (SIGNED),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .ready       (ready),
      .busy        (busy),
      .div_by_zero (div_by_zero)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      forever begin
         @(posedge CLK);
         cyc++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d results outstanding", sb.size());
      $fatal(1);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   // Drive one START pulse; operands are scrambled right after the sampling edge.
   task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                        input int lat, input string nm, input bit push);
      @(negedge CLK);
      START    = 1'b1;
      SIGNED   = sgn;
      dividend = a;
      divisor  = b;
      if (push) sb.push_back('{q: eq, r: er, dbz: edbz, start: cyc + 1, lat: lat, name: nm});
      @(negedge CLK);
      START    = 1'b0;
      SIGNED   = ~sgn;
      dividend = ~a;
      divisor  = b ^ 32'h5A5A_0001;
      check({nm, "_busy_after_start"}, {31'd0, busy}, 32'd1);
      check({nm, "_ready_after_start"}, {31'd0, ready}, 32'd0);
      check({nm, "_dbz_after_start"}, {31'd0, div_by_zero}, 32'd0);
   endtask

   task automatic wait_done(input string nm);
      for (int i = 0; i < 60; i++) begin
         if (ready) return;
         check({nm, "_busy_while_running"}, {31'd0, busy}, 32'd1);
         @(negedge CLK);
      end
      check({nm, "_ready_timeout"}, {31'd0, ready}, 32'd1);
   endtask

   task automatic op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                     input string nm);
      issue(sgn, a, b, eq, er, edbz, edbz ? 1 : 33, nm, 1'b1);
      wait_done(nm);
   endtask

   // Monitor: pops the scoreboard on each rising edge of ready.
   initial begin
      logic rdy_prev;
      exp_t e;
      rdy_prev = 1'b0;
      forever begin
         @(negedge CLK);
         if (RST) begin
            check("busy_and_ready_exclusive", {31'd0, busy & ready}, 32'd0);
            if (ready && !rdy_prev) begin
               if (sb.size() == 0) begin
                  check("unexpected_result", quotient, 32'hDEAD_BEEF);
               end else begin
                  e = sb.pop_front();
                  check({e.name, "_quotient"}, quotient, e.q);
                  check({e.name, "_remainder"}, remainder, e.r);
                  check({e.name, "_div_by_zero"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
                  check({e.name, "_latency"}, 32'(cyc - e.start), 32'(e.lat));
               end
            end
         end
         rdy_prev = ready;
      end
   end

   initial begin
      RST      = 1'b0;
      START    = 1'b0;
      SIGNED   = 1'b0;
      dividend = 32'h0;
      divisor  = 32'h0;
      repeat (3) @(negedge CLK);
      check("reset_quotient", quotient, 32'h0);
      check("reset_remainder", remainder, 32'h0);
      check("reset_ready", {31'd0, ready}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
      RST = 1'b1;

      op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "divu_100_7");
      repeat (5) @(negedge CLK);
      check("done_hold_quotient", quotient, 32'd14);
      check("done_hold_ready", {31'd0, ready}, 32'd1);

      op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, "div_m7_2");
      op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, "div_7_m2");
      op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, "div_m7_m2");
      op(1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, "divu_by_zero");
      op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, "div_overflow");
      op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, "divu_min_allones");
      op(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, "divu_max_1");
      op(1'b1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, "div_m1_1");
      op(1'b0, 32'd5, 32'd10, 32'd0, 32'd5, 1'b0, "divu_5_10");
      op(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 1'b0, "div_max_min");
      op(1'b1, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b1, "div_m100_by_zero");
      op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, "divu_max_max");
      op(1'b1, 32'h8000_0000, 32'd2, 32'hC000_0000, 32'd0, 1'b0, "div_min_2");
      op(1'b0, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, "divu_0_5");

      // Restart: the first operation is abandoned at cycle 10 and never reported.
      issue(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 33, "restart_first", 1'b0);
      repeat (8) @(negedge CLK);
      issue(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 33, "restart_second", 1'b1);
      wait_done("restart_second");

      // Asynchronous reset in the middle of RUN.
      issue(1'b0, 32'd12345, 32'd7, 32'd1763, 32'd4, 1'b0, 33, "reset_victim", 1'b0);
      repeat (5) @(negedge CLK);
      #2 RST = 1'b0;
      #1;
      check("midrun_reset_quotient", quotient, 32'h0);
      check("midrun_reset_remainder", remainder, 32'h0);
      check("midrun_reset_ready", {31'd0, ready}, 32'd0);
      check("midrun_reset_busy", {31'd0, busy}, 32'd0);
      check("midrun_reset_dbz", {31'd0, div_by_zero}, 32'd0);
      @(negedge CLK);
      RST = 1'b1;
      repeat (40) @(negedge CLK);
      check("idle_after_reset_ready", {31'd0, ready}, 32'd0);
      check("idle_after_reset_busy", {31'd0, busy}, 32'd0);

      op(1'b0, 32'd15, 32'd4, 32'd3, 32'd3, 1'b0, "divu_15_4_after_reset");

      repeat (3) @(negedge CLK);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
